// File: rtl/srlz_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : srlz_frame_ctrl_if
// Description : Upstream word handshake (valid/ready/data) for srlz_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface srlz_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/srlz_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : srlz_frame_ctrl
// Description : Frame sequencer for an external PISO: start, data (MSB first),
//               optional parity and stop bits on tx, paced by bit_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module srlz_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   bit_tick,
    srlz_frame_ctrl_if.slave      up,
    output logic                  piso_load,
    output logic [DATA_WIDTH-1:0] piso_data,
    output logic                  piso_shift,
    input  wire                   piso_z,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int                 c_CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(DATA_WIDTH);
    localparam logic [1:0]         c_STOP_LAST = 2'(STOP_BITS);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARM   = 3'd1;
    localparam logic [2:0] c_ST_START = 3'd2;
    localparam logic [2:0] c_ST_DATA  = 3'd3;
    localparam logic [2:0] c_ST_PAR   = 3'd4;
    localparam logic [2:0] c_ST_STOP  = 3'd5;

    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [1:0]            r_stop_cnt;
    logic                  r_tx;
    logic                  r_load;
    logic                  r_done;
    logic                  r_parity;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_accept;
    logic                  w_data_more;

    // Handshake outputs are forced to their idle values while reset is held.
    assign up.in_ready  = !rst_n || (r_state == c_ST_IDLE);
    assign busy         = rst_n && (r_state != c_ST_IDLE);
    assign w_accept     = up.in_valid && up.in_ready;
    assign w_data_more  = (r_bit_cnt < c_BIT_LAST);
    assign piso_shift   = rst_n && bit_tick &&
                          ((r_state == c_ST_START) || ((r_state == c_ST_DATA) && w_data_more));

    assign piso_load    = r_load;
    assign piso_data    = r_data;
    assign tx           = r_tx;
    assign frame_done   = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_tx       <= 1'b1;
            r_load     <= 1'b0;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_done     <= 1'b0;
            r_parity   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_data   <= up.in_data;
                        r_parity <= (^up.in_data) ^ PARITY_ODD;
                        r_load   <= 1'b1;
                        r_state  <= c_ST_ARM;
                    end
                end
                c_ST_ARM: begin
                    if (bit_tick) begin
                        r_tx    <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (bit_tick) begin
                        r_tx      <= piso_z;
                        r_bit_cnt <= c_CNT_W'(1);
                        r_state   <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (bit_tick) begin
                        if (w_data_more) begin
                            r_tx      <= piso_z;
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end else if (PARITY_EN) begin
                            r_tx    <= r_parity;
                            r_state <= c_ST_PAR;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 2'd1;
                            r_state    <= c_ST_STOP;
                        end
                    end
                end
                c_ST_PAR: begin
                    if (bit_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 2'd1;
                        r_state    <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (bit_tick) begin
                        r_tx <= 1'b1;
                        if (r_stop_cnt < c_STOP_LAST) begin
                            r_stop_cnt <= r_stop_cnt + 2'd1;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_srlz_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_srlz_frame_ctrl
// Description : Scoreboard bench for srlz_frame_ctrl across three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srlz_frame_ctrl;
    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] rstn  = 3'b000;
    logic [2:0] tick  = 3'b111;
    logic [2:0] valid = 3'b000;
    logic [7:0] data_a [3] = '{default: 8'h00};

    logic [2:0] ready_a, busy_a, tx_a, done_a, load_a, shift_a;
    logic [7:0] pd_a [3];

    frame_t exp_q [3][$];

    // Instance 0: even parity, 1 stop. 1: odd parity, 1 stop. 2: no parity, 2 stops, slow tick.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_inst
            localparam int SB   = (g == 2) ? 2 : 1;
            localparam bit PEN  = (g == 2) ? 1'b0 : 1'b1;
            localparam bit PODD = (g == 1) ? 1'b1 : 1'b0;

            srlz_frame_ctrl_if #(.DATA_WIDTH(8)) ifc ();
            logic [7:0] sr = 8'h00;
            logic       pl;
            logic       ps;

            assign ifc.in_valid = valid[g];
            assign ifc.in_data  = data_a[g];
            assign ready_a[g]   = ifc.in_ready;
            assign load_a[g]    = pl;
            assign shift_a[g]   = ps;

            srlz_frame_ctrl #(
                .DATA_WIDTH (8),
                .STOP_BITS  (SB),
                .PARITY_EN  (PEN),
                .PARITY_ODD (PODD)
            ) dut (
                .clk        (clk),
                .rst_n      (rstn[g]),
                .bit_tick   (tick[g]),
                .up         (ifc.slave),
                .piso_load  (pl),
                .piso_data  (pd_a[g]),
                .piso_shift (ps),
                .piso_z     (sr[7]),
                .tx         (tx_a[g]),
                .busy       (busy_a[g]),
                .frame_done (done_a[g])
            );

            // External PISO model
            always @(posedge clk) begin
                if (pl)      sr <= pd_a[g];
                else if (ps) sr <= {sr[6:0], 1'b0};
            end
        end
    endgenerate

    int div = 0;
    initial begin
        forever begin
            @(negedge clk);
            div     = (div == 15) ? 0 : div + 1;
            tick[2] = (div == 0);
        end
    end

    // Monitor: samples just before each rising edge, rebuilds frames from tx.
    logic        p_tick [3] = '{default: 1'b0};
    logic        p_busy [3] = '{default: 1'b0};
    logic        p_rst  [3] = '{default: 1'b0};
    logic        p_tx   [3] = '{default: 1'b1};
    logic [15:0] acc    [3] = '{default: 16'h0};
    int          nb     [3] = '{default: 0};
    int          nshift [3] = '{default: 0};
    int          nload  [3] = '{default: 0};
    logic [2:0]  bad    [3] = '{default: 3'b000};

    always begin : mon
        frame_t f;
        @(negedge clk);
        #3;
        for (int g = 0; g < 3; g++) begin
            if (!p_rst[g]) begin
                acc[g] = 16'h0; nb[g] = 0; nshift[g] = 0; nload[g] = 0; bad[g] = 3'b000;
            end else if (p_tick[g] && p_busy[g]) begin
                acc[g] = {acc[g][14:0], tx_a[g]};
                nb[g]++;
            end else if (tx_a[g] !== p_tx[g]) begin
                bad[g][0] = 1'b1;
            end
            if (rstn[g]) begin
                if (!busy_a[g] && tx_a[g] !== 1'b1) bad[g][1] = 1'b1;
                if (busy_a[g] == ready_a[g])        bad[g][2] = 1'b1;
                if (shift_a[g] && load_a[g])        bad[g][2] = 1'b1;
                nshift[g] += int'(shift_a[g]);
                nload[g]  += int'(load_a[g]);
            end
            if (done_a[g]) begin
                checks++;
                if (exp_q[g].size() == 0) begin
                    errors++;
                    $display("FAIL frame%0d: unexpected frame_done, got bits %h, required none", g, acc[g] >> 1);
                end else begin
                    f = exp_q[g].pop_front();
                    if ((acc[g] >> 1) !== f.bits || nb[g] != f.n + 1 || nshift[g] != 8 ||
                        nload[g] != 1 || bad[g] != 3'b000 || ready_a[g] !== 1'b1) begin
                        errors++;
                        $display("FAIL frame%0d: got bits %h ticks %0d shifts %0d loads %0d flags %b rdy %b, required bits %h ticks %0d shifts 8 loads 1 flags 000 rdy 1",
                                 g, acc[g] >> 1, nb[g], nshift[g], nload[g], bad[g], ready_a[g], f.bits, f.n + 1);
                    end
                end
                acc[g] = 16'h0; nb[g] = 0; nshift[g] = 0; nload[g] = 0; bad[g] = 3'b000;
            end
            p_tick[g] = tick[g];
            p_busy[g] = busy_a[g];
            p_rst[g]  = rstn[g];
            p_tx[g]   = tx_a[g];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push(input int g, input logic [15:0] b, input int n);
        frame_t f;
        f.bits = b;
        f.n    = n;
        exp_q[g].push_back(f);
    endtask

    // Offers a word; returns at the falling edge after acceptance with frame_done seen at acceptance.
    task automatic send(input int g, input logic [7:0] d, output logic fd);
        logic ok;
        ok = 1'b0;
        fd = 1'b0;
        @(negedge clk);
        valid[g]  = 1'b1;
        data_a[g] = d;
        for (int i = 0; i < 2000 && !ok; i++) begin
            #3;
            if (ready_a[g]) begin
                ok = 1'b1;
                fd = done_a[g];
            end
            @(negedge clk);
        end
        valid[g] = 1'b0;
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_empty(input int g);
        for (int i = 0; i < 4000 && exp_q[g].size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain", exp_q[g].size(), 32'd0);
    endtask

    initial begin : main
        logic fd;
        int   n;
        logic seen_done;

        repeat (3) @(negedge clk);
        #3;
        for (int g = 0; g < 3; g++) begin
            chk("rst_tx",    {31'd0, tx_a[g]},    32'd1);
            chk("rst_busy",  {31'd0, busy_a[g]},  32'd0);
            chk("rst_ready", {31'd0, ready_a[g]}, 32'd1);
            chk("rst_load",  {31'd0, load_a[g]},  32'd0);
            chk("rst_shift", {31'd0, shift_a[g]}, 32'd0);
            chk("rst_done",  {31'd0, done_a[g]},  32'd0);
            chk("rst_pdata", {24'd0, pd_a[g]},    32'd0);
        end
        @(negedge clk);
        rstn = 3'b111;

        // Even parity, tick held high
        push(0, 16'b0_1010_0101_0_1, 11);
        send(0, 8'hA5, fd);
        wait_empty(0);

        // Back-to-back words; second is offered while busy
        push(0, 16'b0_0001_0010_0_1, 11);
        push(0, 16'b0_0011_0100_1_1, 11);
        send(0, 8'h12, fd);
        send(0, 8'h34, fd);
        chk("b2b_accept_on_done", {31'd0, fd}, 32'd1);
        wait_empty(0);

        // Reset in DATA with bit_cnt=4, then a clean frame
        send(0, 8'h3C, fd);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rstn[0] = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b1;
        #3;
        chk("midrst_tx",    {31'd0, tx_a[0]},    32'd1);
        chk("midrst_busy",  {31'd0, busy_a[0]},  32'd0);
        chk("midrst_ready", {31'd0, ready_a[0]}, 32'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_a[0]) seen_done = 1'b1;
            @(negedge clk);
            #3;
        end
        chk("midrst_no_done", {31'd0, seen_done}, 32'd0);
        push(0, 16'b0_1100_0011_0_1, 11);
        send(0, 8'hC3, fd);
        wait_empty(0);

        // Odd parity
        push(1, 16'b0_0000_0111_0_1, 11);
        push(1, 16'b0_0000_0011_1_1, 11);
        send(1, 8'h07, fd);
        send(1, 8'h03, fd);
        wait_empty(1);

        // No parity, two stops, slow tick; stray valid pulse in STOP
        push(2, 16'b0_1111_1111_1_1, 11);
        send(2, 8'hFF, fd);
        n = 0;
        for (int i = 0; i < 1000 && n < 11; i++) begin
            #3;
            if (tick[2]) n++;
            @(negedge clk);
        end
        #3;
        chk("stop_busy",  {31'd0, busy_a[2]},  32'd1);
        chk("stop_ready", {31'd0, ready_a[2]}, 32'd0);
        @(negedge clk);
        valid[2]  = 1'b1;
        data_a[2] = 8'h55;
        @(negedge clk);
        valid[2]  = 1'b0;
        wait_empty(2);
        repeat (60) @(negedge clk);
        #3;
        chk("stray_ignored", {31'd0, busy_a[2]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/srlz_frame_ctrl.md
Name: srlz_frame_ctrl

Overview:
- Frame sequencer for the transceiver's external parallel-in/serial-out shift register (PISO).
- Accepts parallel words over a valid/ready handshake and drives the PISO's load and shift controls.
- Wraps each word as start bit, DATA_WIDTH data bits (MSB first, taken from the PISO serial output), optional parity, then STOP_BITS stop bits, on the line output tx.
- Bit timing comes from an external single-cycle bit_tick strobe (baud generator).

Parameters:
- DATA_WIDTH, 8, payload bits per frame; supported range 2..32.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- PARITY_EN, 1, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- bit_tick  in  1  one-clk bit-period strobe; may be held high (one bit per clk).
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_WIDTH  upstream word.
- in_ready  out  1  high only in IDLE.
- piso_load  out  1  one-clk load pulse to the PISO.
- piso_data  out  DATA_WIDTH  captured word presented to the PISO parallel input.
- piso_shift  out  1  PISO shift enable; combinational.
- piso_z  in  1  PISO serial output (current MSB).
- tx  out  1  serial line output, registered; idle level 1.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-clk pulse when a frame completes.

Behaviour:
- Reset values (rst_n=0 at a clk edge): state=IDLE, tx=1, piso_load=0, piso_data=0, bit_cnt=0, stop_cnt=0, frame_done=0, parity register=0.
  - Combinational results during reset: busy=0, in_ready=1, piso_shift=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into piso_data, compute parity, go to ARM.
    - Even parity is the XOR-reduce of the word; odd parity is its inverse.
  - ARM: piso_load=1 for exactly the first ARM cycle, which is the cycle after acceptance.
    - On bit_tick: tx<=0 (start bit), go to START. A tick in the first ARM cycle is legal.
  - START: on bit_tick: tx<=piso_z, piso_shift=1 in that same cycle, bit_cnt<=1, go to DATA.
  - DATA: on bit_tick with bit_cnt<DATA_WIDTH: tx<=piso_z, piso_shift=1, bit_cnt++.
  - DATA: on bit_tick with bit_cnt==DATA_WIDTH, no shift:
    - If PARITY_EN: tx<=parity, go to PAR.
    - Otherwise: tx<=1, stop_cnt<=1, go to STOP.
  - PAR: on bit_tick: tx<=1, stop_cnt<=1, go to STOP.
  - STOP: on bit_tick with stop_cnt<STOP_BITS: tx<=1, stop_cnt++.
  - STOP: on bit_tick with stop_cnt==STOP_BITS: go to IDLE. tx stays 1. frame_done=1 in the next cycle, coincident with in_ready=1.
- piso_shift=bit_tick&&((state==START)||(state==DATA&&bit_cnt<DATA_WIDTH)).
  - Exactly DATA_WIDTH shifts per frame.
  - A shift never coincides with piso_load.
- Without bit_tick, all states except IDLE hold; tx holds its value.
- in_valid while busy is ignored and not captured; upstream must hold its word until in_ready.
- Frames go back-to-back with no idle gap beyond the single IDLE cycle in which the next word is accepted.
- Reset mid-frame: the next cycle has tx=1 and state=IDLE. The in-flight word is discarded, no frame_done is issued, and piso_shift=0.
- bit_cnt is ceil(log2(DATA_WIDTH+1)) bits wide and never wraps.

Test Plan:
1. DATA_WIDTH=8, even parity, STOP_BITS=1, bit_tick held high, in_data=0xA5 -> tx after ARM = 0,1,0,1,0,0,1,0,1,0,1. frame_done one cycle after the 12th tick; 8 piso_shift pulses; piso_load once.
2. PARITY_ODD=1, in_data=0x07 -> parity bit 0. in_data=0x03 -> parity bit 1.
3. PARITY_EN=0, STOP_BITS=2, bit_tick every 16 clks, in_data=0xFF -> start 0, eight 1s, two stop 1s, each 16 clks wide. busy high throughout, in_ready low.
4. Two words 0x12 and 0x34 offered back-to-back -> second accepted in the cycle frame_done of the first is asserted; the 0x34 offer made during busy is not lost; tx stays 1 between frames.
5. rst_n=0 during DATA at bit_cnt=4 -> next cycle tx=1, busy=0, in_ready=1, no frame_done. The next accepted word produces a full, correct frame.
6. in_valid pulsed high for one cycle during STOP -> ignored; no extra frame is sent.
